fifo_flags: RTL and testbench

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. It replaces the plain UART FIFO between the UART shift engines and the host-side register interface, where software watermarks and error reporting are required. An optional first-word-fall-through read mode is selected at compile time.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 29 ++
 rtl/fifo_flags.sv | 112 +++++++++++
 tb/tb_fifo_flags.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO with watermark flags.
// Optional compile-time feature: FIFO_FWFT_EN selects first-word-fall-through reads.
package fifo_pkg;

    localparam int FIFO_WORD = 8;
    localparam int FIFO_SIZE = 16;

    // UART FIFO watermark defaults
    localparam int UART_AF_LEVEL = FIFO_SIZE - 2;
    localparam int UART_AE_LEVEL = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WORD = FIFO_WORD,
    parameter int SIZE = FIFO_SIZE,
    localparam int AW  = clog2(SIZE)
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [WORD-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [WORD-1:0] rdata
);

    logic [WORD-1:0] mem [SIZE];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // Read-before-write: a same-address write lands after the old word is captured.
    always_ff @(posedge clk)
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy count, watermark flags, sticky error flags and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle read latency.
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int WORD     = FIFO_WORD,
    parameter int SIZE     = FIFO_SIZE,
    parameter int AF_LEVEL = SIZE - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = clog2(SIZE),
    localparam int CW      = AW + 1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            clr_err,
    input  logic            wr,
    input  logic [WORD-1:0] wr_data,
    input  logic            rd,
    output logic [WORD-1:0] rd_data,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic            underflow
);

    logic [AW-1:0]   wp, rp;
    logic            rd_ok, wr_ok;
    logic            ram_re;
    logic [AW-1:0]   ram_raddr;
    logic [WORD-1:0] ram_q;

    // Flags decode the count register only, never wr/rd.
    assign full         = (count == CW'(SIZE));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // A write into a full FIFO is accepted when a read frees a slot the same cycle.
    assign rd_ok = rd & ~empty & ~flush;
    assign wr_ok = wr & (~full | rd_ok) & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(wr_ok);
            rp    <= rp + AW'(rd_ok);
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // Sticky errors: a same-cycle error event beats clr_err; flush raises nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr & ~wr_ok & ~flush) overflow <= 1'b1;
            else if (clr_err)         overflow <= 1'b0;
            if (rd & ~rd_ok & ~flush) underflow <= 1'b1;
            else if (clr_err)         underflow <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    logic            byp_vld;
    logic [WORD-1:0] byp_data;

    // Head register tracks the post-pop read pointer every cycle.
    assign ram_re    = ~flush;
    assign ram_raddr = rp + AW'(rd_ok);

    // The RAM cannot return a word written this edge, so a write that becomes the
    // new head is forwarded directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_vld  <= 1'b0;
            byp_data <= '0;
        end else if (!flush) begin
            byp_vld <= wr_ok && (count == CW'(rd_ok));
            if (wr_ok) byp_data <= wr_data;
        end
    end

    assign rd_data = byp_vld ? byp_data : ram_q;
`else
    assign ram_re    = rd_ok;
    assign ram_raddr = rp;
    assign rd_data   = ram_q;
`endif

    fifo_ram #(
        .WORD (WORD),
        .SIZE (SIZE)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok & ~rst),
        .waddr (wp),
        .wdata (wr_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags (standard read mode), WORD=4 SIZE=4 AF=3 AE=1.
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       rst, flush, clr_err, wr, rd;
    logic [3:0] wr_data, rd_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_flags #(.WORD(4), .SIZE(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .clr_err      (clr_err),
        .wr           (wr),
        .wr_data      (wr_data),
        .rd           (rd),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic w, input logic [3:0] d, input logic r,
                       input logic f = 1'b0, input logic c = 1'b0, input logic rs = 1'b0);
        wr = w; wr_data = d; rd = r; flush = f; clr_err = c; rst = rs;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".rd_data"}, 8'(rd_data), 8'h0);
        chk({tag, ".count"}, 8'(count), 8'h0);
        chk({tag, ".empty"}, 8'(empty), 8'h1);
        chk({tag, ".full"}, 8'(full), 8'h0);
        chk({tag, ".ae"}, 8'(almost_empty), 8'h1);
        chk({tag, ".af"}, 8'(almost_full), 8'h0);
        chk({tag, ".ovf"}, 8'(overflow), 8'h0);
        chk({tag, ".unf"}, 8'(underflow), 8'h0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; clr_err = 1'b0; wr = 1'b0; rd = 1'b0; wr_data = '0;
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk_reset_state("reset");

        // Fill past capacity: writes 4 and 5 are rejected.
        for (int i = 0; i < 6; i++) begin
            cyc(1, 4'(i), 0);
            chk($sformatf("wr%0d.count", i), 8'(count), (i < 4) ? 8'(i + 1) : 8'd4);
            chk($sformatf("wr%0d.af", i), 8'(almost_full), (i >= 2) ? 8'd1 : 8'd0);
            chk($sformatf("wr%0d.full", i), 8'(full), (i >= 3) ? 8'd1 : 8'd0);
            chk($sformatf("wr%0d.ae", i), 8'(almost_empty), (i == 0) ? 8'd1 : 8'd0);
            chk($sformatf("wr%0d.ovf", i), 8'(overflow), (i >= 4) ? 8'd1 : 8'd0);
        end

        // Drain past empty: reads 4 and 5 are rejected, rd_data holds.
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1);
            chk($sformatf("rd%0d.data", i), 8'(rd_data), (i < 4) ? 8'(i) : 8'd3);
            chk($sformatf("rd%0d.count", i), 8'(count), (i < 4) ? 8'(3 - i) : 8'd0);
            chk($sformatf("rd%0d.empty", i), 8'(empty), (i >= 3) ? 8'd1 : 8'd0);
            chk($sformatf("rd%0d.ae", i), 8'(almost_empty), (i >= 2) ? 8'd1 : 8'd0);
            chk($sformatf("rd%0d.unf", i), 8'(underflow), (i >= 4) ? 8'd1 : 8'd0);
        end

        cyc(0, 0, 0, 0, 1);
        chk("clr.ovf", 8'(overflow), 8'h0);
        chk("clr.unf", 8'(underflow), 8'h0);

        // Simultaneous write and read on a full FIFO.
        for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0);
        chk("pre_wr_rd.full", 8'(full), 8'h1);
        cyc(1, 4'd9, 1);
        chk("full_wr_rd.data", 8'(rd_data), 8'h1);
        chk("full_wr_rd.count", 8'(count), 8'h4);
        chk("full_wr_rd.ovf", 8'(overflow), 8'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1);
            chk($sformatf("drain%0d.data", i), 8'(rd_data), (i < 3) ? 8'(i + 2) : 8'h9);
        end
        chk("drain.empty", 8'(empty), 8'h1);
        chk("drain.unf", 8'(underflow), 8'h0);

        // Write and read on empty: write accepted, read rejected.
        cyc(1, 4'd7, 1);
        chk("empty_wr_rd.count", 8'(count), 8'h1);
        chk("empty_wr_rd.unf", 8'(underflow), 8'h1);
        chk("empty_wr_rd.data", 8'(rd_data), 8'h9);
        cyc(0, 0, 1);
        chk("rd7.data", 8'(rd_data), 8'h7);
        chk("rd7.count", 8'(count), 8'h0);
        // Error event in the same cycle as clr_err keeps the flag set.
        cyc(0, 0, 1, 0, 1);
        chk("clr_vs_set.unf", 8'(underflow), 8'h1);
        cyc(0, 0, 0, 0, 1);
        chk("clr2.unf", 8'(underflow), 8'h0);

        // Flush with a write pending, then flush with a read on empty.
        for (int i = 1; i <= 3; i++) cyc(1, 4'(i + 10), 0);
        chk("pre_flush.count", 8'(count), 8'h3);
        cyc(1, 4'd5, 0, 1);
        chk("flush.count", 8'(count), 8'h0);
        chk("flush.empty", 8'(empty), 8'h1);
        chk("flush.ovf", 8'(overflow), 8'h0);
        chk("flush.data", 8'(rd_data), 8'h7);
        cyc(0, 0, 1, 1);
        chk("flush_rd.unf", 8'(underflow), 8'h0);
        cyc(1, 4'd2, 0);
        cyc(0, 0, 1);
        chk("post_flush.data", 8'h2 == 8'(rd_data) ? 8'h2 : 8'(rd_data), 8'h2);

        // Reset mid-stream dominates a concurrent write.
        cyc(1, 4'd3, 0);
        cyc(1, 4'd4, 0);
        cyc(1, 4'd8, 1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 4'd5, 1, 1, 1, 1);
        chk_reset_state("midrst");
        cyc(0, 0, 1);
        chk("midrst_rd.unf", 8'(underflow), 8'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
